// File: rtl/banked_multiport_memory_if.sv
// Requester-side bundle for banked_multiport_memory: per-requester read address/data
// channels and write channels, flattened into packed per-requester vectors.
interface banked_multiport_memory_if #(
  parameter int REQUESTERS = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [REQUESTERS-1:0][ADDR_WIDTH-1:0] r_addr;
  logic [REQUESTERS-1:0]                 r_avalid;
  logic [REQUESTERS-1:0]                 r_aready;
  logic [REQUESTERS-1:0]                 r_dvalid;
  logic [REQUESTERS-1:0][DATA_WIDTH-1:0] r_data;
  logic [REQUESTERS-1:0][ADDR_WIDTH-1:0] w_addr;
  logic [REQUESTERS-1:0][DATA_WIDTH-1:0] w_data;
  logic [REQUESTERS-1:0]                 w_valid;
  logic [REQUESTERS-1:0]                 w_ready;

  modport master (
    output r_addr, r_avalid, w_addr, w_data, w_valid,
    input  r_aready, r_dvalid, r_data, w_ready
  );

  modport slave (
    input  r_addr, r_avalid, w_addr, w_data, w_valid,
    output r_aready, r_dvalid, r_data, w_ready
  );
endinterface

// File: rtl/banked_multiport_memory.sv
// Interleaved multi-bank RAM with per-bank round-robin read/write arbiters; read data returns
// RD_LAT cycles after accept to the issuing requester only; losers see ready=0 and must hold.
module banked_multiport_memory #(
  parameter int REQUESTERS = 3,
  parameter int BANKS      = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int RD_LAT     = 2
) (
  input logic clk,
  input logic rst,
  banked_multiport_memory_if.slave bus
);

  localparam int LB    = $clog2(BANKS);
  localparam int BW    = (LB > 0) ? LB : 1;
  localparam int ROW_W = ADDR_WIDTH - LB;
  localparam int ROWS  = 1 << ROW_W;
  localparam int PW    = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

  typedef logic [BW-1:0]         bank_t;
  typedef logic [ROW_W-1:0]      row_t;
  typedef logic [REQUESTERS-1:0] req_vec_t;
  typedef logic [PW-1:0]         ptr_t;

  function automatic bank_t bank_of(input logic [ADDR_WIDTH-1:0] a);
    if (LB == 0) return '0;
    return a[BW-1:0];
  endfunction

  function automatic row_t row_of(input logic [ADDR_WIDTH-1:0] a);
    return row_t'(a >> LB);
  endfunction

  // First requesting index at or after ptr, wrapping; one-hot result.
  function automatic req_vec_t rr_pick(input req_vec_t req, input ptr_t ptr);
    req_vec_t g;
    int       idx;
    g = '0;
    for (int k = 0; k < REQUESTERS; k++) begin
      idx = (int'(ptr) + k) % REQUESTERS;
      if (g == '0 && req[idx]) g[idx] = 1'b1;
    end
    return g;
  endfunction

  function automatic ptr_t oh_idx(input req_vec_t oh);
    ptr_t r;
    r = '0;
    for (int i = 0; i < REQUESTERS; i++)
      if (oh[i]) r = ptr_t'(i);
    return r;
  endfunction

  function automatic ptr_t next_ptr(input ptr_t g);
    return ptr_t'((int'(g) + 1) % REQUESTERS);
  endfunction

  req_vec_t r_req [BANKS];
  req_vec_t w_req [BANKS];
  req_vec_t r_gnt [BANKS];
  req_vec_t w_gnt [BANKS];
  ptr_t     w_gidx[BANKS];
  ptr_t     r_ptr [BANKS];
  ptr_t     w_ptr [BANKS];

  // Reset gates every request so ready is forced low while rst is asserted.
  always_comb begin
    bus.r_aready = '0;
    bus.w_ready  = '0;
    for (int b = 0; b < BANKS; b++) begin
      r_req[b] = '0;
      w_req[b] = '0;
      for (int i = 0; i < REQUESTERS; i++) begin
        r_req[b][i] = !rst && bus.r_avalid[i] && (bank_of(bus.r_addr[i]) == bank_t'(b));
        w_req[b][i] = !rst && bus.w_valid[i]  && (bank_of(bus.w_addr[i]) == bank_t'(b));
      end
      r_gnt[b]  = rr_pick(r_req[b], r_ptr[b]);
      w_gnt[b]  = rr_pick(w_req[b], w_ptr[b]);
      w_gidx[b] = oh_idx(w_gnt[b]);
      bus.r_aready = bus.r_aready | r_gnt[b];
      bus.w_ready  = bus.w_ready  | w_gnt[b];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < BANKS; b++) begin
        r_ptr[b] <= '0;
        w_ptr[b] <= '0;
      end
    end else begin
      for (int b = 0; b < BANKS; b++) begin
        if (r_gnt[b] != '0) r_ptr[b] <= next_ptr(oh_idx(r_gnt[b]));
        if (w_gnt[b] != '0) w_ptr[b] <= next_ptr(w_gidx[b]);
      end
    end
  end

  logic [DATA_WIDTH-1:0] mem [BANKS][ROWS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < BANKS; b++)
      if (w_gnt[b] != '0)
        mem[b][row_of(bus.w_addr[w_gidx[b]])] <= bus.w_data[w_gidx[b]];
  end

  // Memory is sampled at the accept edge, so a same-cycle write to that row is not seen.
  logic [RD_LAT-1:0]     pv [REQUESTERS];
  logic [DATA_WIDTH-1:0] pd [REQUESTERS][RD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REQUESTERS; i++) begin
        pv[i] <= '0;
        for (int s = 0; s < RD_LAT; s++) pd[i][s] <= '0;
      end
    end else begin
      for (int i = 0; i < REQUESTERS; i++) begin
        pv[i][0] <= bus.r_aready[i];
        if (bus.r_aready[i])
          pd[i][0] <= mem[bank_of(bus.r_addr[i])][row_of(bus.r_addr[i])];
        for (int s = 1; s < RD_LAT; s++) begin
          pv[i][s] <= pv[i][s-1];
          if (pv[i][s-1]) pd[i][s] <= pd[i][s-1];
        end
      end
    end
  end

  always_comb begin
    bus.r_dvalid = '0;
    bus.r_data   = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      bus.r_dvalid[i] = pv[i][RD_LAT-1];
      bus.r_data[i]   = pd[i][RD_LAT-1];
    end
  end

endmodule

// File: tb/tb_banked_multiport_memory.sv
// Directed and randomized bench for banked_multiport_memory against an address-level model.
module tb_banked_multiport_memory;
  localparam int R   = 3;
  localparam int NB  = 2;
  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  banked_multiport_memory_if #(.REQUESTERS(R), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  banked_multiport_memory #(
    .REQUESTERS(R), .BANKS(NB), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LAT(LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model state: flat word memory, per-bank pointers, reads in flight with due cycle.
  logic [DW-1:0] mm [32];
  int            rptr [NB];
  int            wptr [NB];
  typedef struct { int req; int due; logic [DW-1:0] d; } rd_t;
  rd_t           pend [$];
  logic [DW-1:0] last_d [R];
  int            cyc;
  logic [R-1:0]  racc, wacc;

  // DUT outputs as sampled in the most recent tick.
  logic [R-1:0]  s_rrdy, s_wrdy, s_dv;
  logic [DW-1:0] s_rd [R];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [R-1:0] m, input int p);
    for (int k = 0; k < R; k++)
      if (m[(p + k) % R]) return (p + k) % R;
    return -1;
  endfunction

  function automatic logic [DW-1:0] pl(input int a);
    return 32'hC0DE_0000 + a;
  endfunction

  task automatic clear_in();
    bus.r_avalid = '0;
    bus.w_valid  = '0;
    bus.r_addr   = '0;
    bus.w_addr   = '0;
    bus.w_data   = '0;
  endtask

  task automatic model_reset();
    pend.delete();
    for (int b = 0; b < NB; b++) begin
      rptr[b] = 0;
      wptr[b] = 0;
    end
    for (int i = 0; i < R; i++) last_d[i] = '0;
  endtask

  // One clock cycle: check outputs against the model, advance the model, step past the edge.
  task automatic tick();
    logic [R-1:0]  exp_r, exp_w, exp_dv;
    logic [DW-1:0] exp_d [R];
    rd_t           keep [$];
    logic [R-1:0]  rm, wm;
    int            g;
    #1;
    exp_r = '0;
    exp_w = '0;
    for (int b = 0; b < NB; b++) begin
      rm = '0;
      wm = '0;
      for (int i = 0; i < R; i++) begin
        rm[i] = bus.r_avalid[i] && (int'(bus.r_addr[i]) % NB == b);
        wm[i] = bus.w_valid[i]  && (int'(bus.w_addr[i]) % NB == b);
      end
      g = pick(rm, rptr[b]);
      if (g >= 0) begin exp_r[g] = 1'b1; rptr[b] = (g + 1) % R; end
      g = pick(wm, wptr[b]);
      if (g >= 0) begin exp_w[g] = 1'b1; wptr[b] = (g + 1) % R; end
    end
    exp_dv = '0;
    for (int i = 0; i < R; i++) exp_d[i] = last_d[i];
    foreach (pend[k]) begin
      if (pend[k].due == cyc) begin
        exp_dv[pend[k].req] = 1'b1;
        exp_d[pend[k].req]  = pend[k].d;
      end else begin
        keep.push_back(pend[k]);
      end
    end
    pend = keep;
    s_rrdy = bus.r_aready;
    s_wrdy = bus.w_ready;
    s_dv   = bus.r_dvalid;
    for (int i = 0; i < R; i++) s_rd[i] = bus.r_data[i];
    chk("r_aready", s_rrdy, exp_r);
    chk("w_ready", s_wrdy, exp_w);
    chk("r_dvalid", s_dv, exp_dv);
    for (int i = 0; i < R; i++) begin
      chk($sformatf("r_data%0d", i), s_rd[i], exp_d[i]);
      last_d[i] = exp_d[i];
    end
    for (int i = 0; i < R; i++)
      if (exp_r[i]) pend.push_back('{req: i, due: cyc + LAT, d: mm[bus.r_addr[i]]});
    for (int i = 0; i < R; i++)
      if (exp_w[i]) mm[bus.w_addr[i]] = bus.w_data[i];
    racc = exp_r;
    wacc = exp_w;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  logic [R-1:0]  rv, wv;

  initial begin
    cyc = 0;
    model_reset();
    clear_in();
    rst = 1'b1;
    // Reset state, with requests presented to prove ready stays low.
    bus.r_avalid = '1;
    bus.w_valid  = '1;
    #1;
    chk("rst_r_aready", bus.r_aready, 3'b000);
    chk("rst_w_ready", bus.w_ready, 3'b000);
    chk("rst_r_dvalid", bus.r_dvalid, 3'b000);
    chk("rst_r_data", bus.r_data, '0);
    clear_in();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Test 1: write by requester 0, read back by requester 2 only.
    bus.w_valid[0] = 1'b1; bus.w_addr[0] = 5'd4; bus.w_data[0] = 32'hA5A5_0001;
    tick();
    chk("t1_wready", s_wrdy, 3'b001);
    clear_in();
    bus.r_avalid[2] = 1'b1; bus.r_addr[2] = 5'd4;
    tick();
    chk("t1_aready", s_rrdy, 3'b100);
    clear_in();
    tick();
    chk("t1_dv_early", s_dv, 3'b000);
    tick();
    chk("t1_dvalid", s_dv, 3'b100);
    chk("t1_data", s_rd[2], 32'hA5A5_0001);

    // Preload every address through requester 2.
    for (int a = 0; a < 32; a++) begin
      clear_in();
      bus.w_valid[2] = 1'b1; bus.w_addr[2] = AW'(a); bus.w_data[2] = pl(a);
      tick();
    end
    clear_in();

    // Test 2: three requesters hammer bank 0; grants rotate.
    bus.r_avalid = 3'b111;
    bus.r_addr[0] = 5'd0; bus.r_addr[1] = 5'd2; bus.r_addr[2] = 5'd4;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t2_grant", s_rrdy, 3'b001 << (k % 3));
      if (k >= 2) begin
        chk("t2_dvalid", s_dv, 3'b001 << ((k - 2) % 3));
        chk("t2_data", s_rd[(k - 2) % 3], pl(2 * ((k - 2) % 3)));
      end
    end
    clear_in();
    tick();
    tick();

    // Test 3: different banks accept in the same cycle.
    bus.r_avalid = 3'b011; bus.r_addr[0] = 5'd0; bus.r_addr[1] = 5'd1;
    tick();
    chk("t3_aready", s_rrdy, 3'b011);
    clear_in();
    tick();
    tick();
    chk("t3_dvalid", s_dv, 3'b011);
    chk("t3_data0", s_rd[0], pl(0));
    chk("t3_data1", s_rd[1], pl(1));

    // Test 4: same-row read and write in one cycle returns old data.
    bus.w_valid[0] = 1'b1; bus.w_addr[0] = 5'd6; bus.w_data[0] = 32'h11;
    tick();
    clear_in();
    bus.w_valid[1] = 1'b1; bus.w_addr[1] = 5'd6; bus.w_data[1] = 32'h22;
    bus.r_avalid[0] = 1'b1; bus.r_addr[0] = 5'd6;
    tick();
    chk("t4_wready", s_wrdy, 3'b010);
    chk("t4_aready", s_rrdy, 3'b001);
    clear_in();
    tick();
    tick();
    chk("t4_old", s_rd[0], 32'h11);
    bus.r_avalid[0] = 1'b1; bus.r_addr[0] = 5'd6;
    tick();
    clear_in();
    tick();
    tick();
    chk("t4_new", s_rd[0], 32'h22);

    // Test 5: two writers on bank 1, round-robin from pointer 0.
    bus.w_valid = 3'b101;
    bus.w_addr[0] = 5'd9; bus.w_data[0] = 32'h55;
    bus.w_addr[2] = 5'd9; bus.w_data[2] = 32'h66;
    tick();
    chk("t5_first", s_wrdy, 3'b001);
    bus.w_valid[0] = 1'b0;
    tick();
    chk("t5_second", s_wrdy, 3'b100);
    clear_in();
    bus.r_avalid[1] = 1'b1; bus.r_addr[1] = 5'd9;
    tick();
    clear_in();
    tick();
    tick();
    chk("t5_final", s_rd[1], 32'h66);

    // Test 6: reset with a read in flight.
    bus.r_avalid[1] = 1'b1; bus.r_addr[1] = 5'd0;
    tick();
    chk("t6_accept", s_rrdy, 3'b010);
    bus.r_avalid = 3'b111; bus.w_valid = 3'b111;
    rst = 1'b1;
    #1;
    chk("t6_r_aready", bus.r_aready, 3'b000);
    chk("t6_w_ready", bus.w_ready, 3'b000);
    chk("t6_r_dvalid", bus.r_dvalid, 3'b000);
    chk("t6_r_data", bus.r_data, '0);
    model_reset();
    clear_in();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t6_no_dvalid", s_dv, 3'b000);
    end
    bus.r_avalid = 3'b110; bus.r_addr[1] = 5'd0; bus.r_addr[2] = 5'd2;
    tick();
    chk("t6_first_grant", s_rrdy, 3'b010);
    bus.r_avalid[1] = 1'b0;
    tick();
    chk("t6_second_grant", s_rrdy, 3'b100);
    clear_in();
    tick();
    tick();

    // Randomized traffic; requests are held until accepted.
    rv = '0;
    wv = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < R; i++) begin
        if (!rv[i] && $urandom_range(0, 99) < 60) begin
          rv[i] = 1'b1;
          bus.r_addr[i] = AW'($urandom_range(0, 31));
        end
        if (!wv[i] && $urandom_range(0, 99) < 40) begin
          wv[i] = 1'b1;
          bus.w_addr[i] = AW'($urandom_range(0, 31));
          bus.w_data[i] = $urandom;
        end
      end
      bus.r_avalid = rv;
      bus.w_valid  = wv;
      tick();
      rv = rv & ~racc;
      wv = wv & ~wacc;
    end
    clear_in();
    for (int k = 0; k < LAT + 1; k++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
